fx2_cmd_parser: RTL

- Byte-stream command decoder downstream of the FX2 OUT-endpoint (EP2) reader.
- Consumes host bytes over a valid/ready handshake and decodes three packet types:
  - register writes into the timetagger/sequencer register file;
  - run-control strobes for detectors and pulse sequencers;
  - register reads, returned as a 4-byte reply stream toward the EP6 IN path.
- Sits between the FX2 slave-FIFO interface and the fx2_timetag core registers.

---
 rtl/fx2_cmd_parser.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fx2_cmd_parser.sv
// rtl/fx2_cmd_parser.sv - EP2 command byte decoder: register write/read and run-control packets
module fx2_cmd_parser #(
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] CMD_CTRL = 8'h01,
    parameter logic [7:0] CMD_RD   = 8'h04,
    parameter logic [7:0] CMD_WR   = 8'h05
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_avail_i,
    output logic        cmd_ack_o,
    output logic [7:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    input  logic [31:0] reg_rdata_i,
    output logic [7:0]  reply_data_o,
    output logic        reply_valid_o,
    input  logic        reply_ready_i,
    output logic [7:0]  ctrl_target_o,
    output logic [7:0]  ctrl_value_o,
    output logic        ctrl_strobe_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE, S_CTRL_TGT, S_CTRL_VAL, S_WR_LEN, S_WR_DATA,
        S_WR_ADDR, S_RD_ADDR, S_RD_ISSUE, S_RD_CAPT, S_RD_SEND
    } state_t;

    state_t        state_q;
    logic          cmd_ack_q;
    logic [7:0]    reg_addr_q;
    logic [31:0]   reg_wdata_q;
    logic          reg_wr_q;
    logic          reg_rd_q;
    logic [31:0]   rd_shift_q;
    logic          reply_valid_q;
    logic [7:0]    ctrl_target_q;
    logic [7:0]    ctrl_value_q;
    logic          ctrl_strobe_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic [1:0]    byte_cnt_q;
    logic [TW-1:0] tmo_cnt_q;

    logic xfer;
    logic tmo_active;
    logic tmo_expire;

    assign xfer       = cmd_avail_i & cmd_ack_q;
    assign tmo_active = (state_q == S_CTRL_TGT) || (state_q == S_CTRL_VAL) ||
                        (state_q == S_WR_LEN)   || (state_q == S_WR_DATA)  ||
                        (state_q == S_WR_ADDR)  || (state_q == S_RD_ADDR);
    assign tmo_expire = (TIMEOUT != 0) && tmo_active && !xfer && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            cmd_ack_q     <= 1'b1;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            reg_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
            rd_shift_q    <= '0;
            reply_valid_q <= 1'b0;
            ctrl_target_q <= '0;
            ctrl_value_q  <= '0;
            ctrl_strobe_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            byte_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            reg_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
            ctrl_strobe_q <= 1'b0;
            err_q         <= 1'b0;
            tmo_cnt_q     <= (tmo_active && !xfer) ? tmo_cnt_q + TW'(1) : '0;

            case (state_q)
                S_IDLE: begin
                    cmd_ack_q <= 1'b1;
                    if (xfer) begin
                        if (cmd_data_i == CMD_CTRL) begin
                            state_q <= S_CTRL_TGT;
                        end else if (cmd_data_i == CMD_WR) begin
                            state_q <= S_WR_LEN;
                        end else if (cmd_data_i == CMD_RD) begin
                            state_q <= S_RD_ADDR;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                        end
                    end
                end
                S_CTRL_TGT: if (xfer) begin
                    ctrl_target_q <= cmd_data_i;
                    state_q       <= S_CTRL_VAL;
                end
                // Completion cycles drop cmd_ack so the strobe cycle never overlaps a new opcode
                S_CTRL_VAL: if (xfer) begin
                    ctrl_value_q  <= cmd_data_i;
                    ctrl_strobe_q <= 1'b1;
                    cmd_ack_q     <= 1'b0;
                    state_q       <= S_IDLE;
                end
                S_WR_LEN: if (xfer) begin
                    if (cmd_data_i == 8'h04) begin
                        byte_cnt_q <= '0;
                        state_q    <= S_WR_DATA;
                    end else begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'd2;
                        state_q    <= S_IDLE;
                    end
                end
                S_WR_DATA: if (xfer) begin
                    reg_wdata_q <= {reg_wdata_q[23:0], cmd_data_i};
                    byte_cnt_q  <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_q <= S_WR_ADDR;
                end
                S_WR_ADDR: if (xfer) begin
                    reg_addr_q <= cmd_data_i;
                    reg_wr_q   <= 1'b1;
                    cmd_ack_q  <= 1'b0;
                    state_q    <= S_IDLE;
                end
                S_RD_ADDR: if (xfer) begin
                    reg_addr_q <= cmd_data_i;
                    reg_rd_q   <= 1'b1;
                    cmd_ack_q  <= 1'b0;
                    state_q    <= S_RD_ISSUE;
                end
                S_RD_ISSUE: state_q <= S_RD_CAPT;
                S_RD_CAPT: begin
                    rd_shift_q    <= reg_rdata_i;
                    reply_valid_q <= 1'b1;
                    byte_cnt_q    <= '0;
                    state_q       <= S_RD_SEND;
                end
                S_RD_SEND: if (reply_valid_q && reply_ready_i) begin
                    rd_shift_q <= {rd_shift_q[23:0], 8'h00};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        reply_valid_q <= 1'b0;
                        cmd_ack_q     <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ack_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase

            // A stalled host aborts the partial packet without any strobe
            if (tmo_expire) begin
                err_q      <= 1'b1;
                err_code_q <= 2'd3;
                cmd_ack_q  <= 1'b1;
                state_q    <= S_IDLE;
            end
        end
    end

    assign cmd_ack_o     = cmd_ack_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_wdata_o   = reg_wdata_q;
    assign reg_wr_o      = reg_wr_q;
    assign reg_rd_o      = reg_rd_q;
    assign reply_data_o  = rd_shift_q[31:24];
    assign reply_valid_o = reply_valid_q;
    assign ctrl_target_o = ctrl_target_q;
    assign ctrl_value_o  = ctrl_value_q;
    assign ctrl_strobe_o = ctrl_strobe_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
